// File: rtl/drc_tag_store.sv
// rtl/drc_tag_store.sv - set-associative tag store with round-robin victim selection and INIT sweep
module drc_tag_store #(
    parameter int N_WAY     = 4,
    parameter int TAG_SIZE  = 20,
    parameter int IDX_SIZE  = 4,
    parameter int WAY_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rd_req_i,
    input  logic [IDX_SIZE-1:0]                rd_index_i,
    output logic [N_WAY-1:0]                   rdata_valid_o,
    output logic [N_WAY-1:0][TAG_SIZE:0]       rdata_tag_o,
    input  logic                               upd_valid_i,
    input  logic [IDX_SIZE-1:0]                upd_index_i,
    input  logic [TAG_SIZE-1:0]                upd_tag_i,
    input  logic                               upd_hit_i,
    input  logic [WAY_WIDTH-1:0]               upd_hit_way_i,
    input  logic                               flush_i,
    output logic                               ready_o,
    output logic                               alloc_valid_o,
    output logic [WAY_WIDTH-1:0]               alloc_way_o,
    output logic                               alloc_evict_o,
    output logic [TAG_SIZE-1:0]                evict_tag_o
);
    localparam int N_SET = 1 << IDX_SIZE;

    typedef enum logic {INIT, READY} state_t;

    state_t                state_q, state_d;
    logic [IDX_SIZE-1:0]   cnt_q, cnt_d;

    logic [N_WAY-1:0]      valid_mem [N_SET];
    logic [TAG_SIZE-1:0]   tag_mem   [N_SET][N_WAY];
    logic [WAY_WIDTH-1:0]  ptr_mem   [N_SET];

    logic                  lookup_en, upd_en, miss_en;
    logic [N_WAY-1:0]      set_valid;
    logic [WAY_WIDTH-1:0]  set_ptr, first_inv, victim;
    logic                  any_inv, victim_valid;
    logic [TAG_SIZE-1:0]   victim_tag;
    logic [N_WAY-1:0]      rd_valid;
    logic [TAG_SIZE-1:0]   rd_tag [N_WAY];

    // The hit way only matters to the upstream forwarding check; a hit changes nothing here.
    logic unused_hit_way;
    assign unused_hit_way = ^upd_hit_way_i;

    assign ready_o   = (state_q == READY);
    assign lookup_en = ready_o && rd_req_i;
    assign upd_en    = ready_o && upd_valid_i && !flush_i;
    assign miss_en   = upd_en && !upd_hit_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = INIT;
            cnt_d   = '0;
        end else if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign set_valid = valid_mem[upd_index_i];
    assign set_ptr   = ptr_mem[upd_index_i];

    always_comb begin
        first_inv = '0;
        any_inv   = 1'b0;
        for (int w = N_WAY - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                first_inv = WAY_WIDTH'(w);
                any_inv   = 1'b1;
            end
        end
        victim       = any_inv ? first_inv : set_ptr;
        victim_valid = set_valid[victim];
        victim_tag   = tag_mem[upd_index_i][victim];
    end

    // Write-first: a same-set miss in this cycle is merged into the lookup result.
    always_comb begin
        rd_valid = valid_mem[rd_index_i];
        for (int w = 0; w < N_WAY; w++) begin
            rd_tag[w] = tag_mem[rd_index_i][w];
        end
        if (miss_en && (rd_index_i == upd_index_i)) begin
            rd_valid[victim] = 1'b1;
            rd_tag[victim]   = upd_tag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            valid_mem[cnt_q] <= '0;
            ptr_mem[cnt_q]   <= '0;
        end else if (miss_en) begin
            valid_mem[upd_index_i][victim] <= 1'b1;
            tag_mem[upd_index_i][victim]   <= upd_tag_i;
            if (!any_inv) begin
                ptr_mem[upd_index_i] <= (set_ptr == WAY_WIDTH'(N_WAY - 1)) ? '0 : set_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_valid_o <= '0;
            rdata_tag_o   <= '0;
            alloc_valid_o <= 1'b0;
            alloc_way_o   <= '0;
            alloc_evict_o <= 1'b0;
            evict_tag_o   <= '0;
        end else begin
            if (lookup_en) begin
                rdata_valid_o <= rd_valid;
                for (int w = 0; w < N_WAY; w++) begin
                    rdata_tag_o[w] <= {1'b0, rd_tag[w]};
                end
            end
            alloc_valid_o <= miss_en;
            if (miss_en) begin
                alloc_way_o   <= victim;
                alloc_evict_o <= victim_valid;
                evict_tag_o   <= victim_valid ? victim_tag : '0;
            end
        end
    end
endmodule

// File: doc/drc_tag_store.md
DRC_TAG_STORE -- requirements
Module: drc_tag_store

Interface
REQ-001 SHALL have parameters: N_WAY, 4, associativity; TAG_SIZE, 20, tag width; IDX_SIZE, 4, set-index width; WAY_WIDTH, 2, way-number width (log2 N_WAY).
REQ-002 SHALL have a single clock and an asynchronous, active-low reset, with ports clk and rst_n listed first: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 rd_req_i  in  1  tag lookup request for a set.
REQ-004 rd_index_i  in  IDX_SIZE  set index of the lookup.
REQ-005 rdata_valid_o[N_WAY]  out  1 each  per-way valid bit of the looked-up set.
REQ-006 rdata_tag_o[N_WAY]  out  TAG_SIZE+1 each  per-way stored tag; the MSB always reads 0.
REQ-007 upd_valid_i  in  1  comparator result is presented this cycle.
REQ-008 upd_index_i  in  IDX_SIZE  set index of the result.
REQ-009 upd_tag_i  in  TAG_SIZE  tag of the result.
REQ-010 upd_hit_i  in  1  1 = hit, 0 = miss.
REQ-011 upd_hit_way_i  in  WAY_WIDTH  way that hit; used for the forwarding check only.
REQ-012 flush_i  in  1  request to invalidate all entries.
REQ-013 ready_o  out  1  store accepts lookups and updates.
REQ-014 alloc_valid_o  out  1  one-cycle pulse reporting an allocation.
REQ-015 alloc_way_o  out  WAY_WIDTH  way that was allocated.
REQ-016 alloc_evict_o  out  1  the allocated way previously held a valid entry.
REQ-017 evict_tag_o  out  TAG_SIZE  tag that was displaced by the allocation.

Function
REQ-018 Storage SHALL be 2^IDX_SIZE sets x N_WAY ways; each entry holds {valid, tag}, and each set holds a WAY_WIDTH-bit round-robin pointer.
REQ-019 The FSM SHALL have two states: INIT and READY. ready_o SHALL be 1 only in READY.
REQ-020 INIT SHALL sweep a set counter from 0 to 2^IDX_SIZE-1, one set per cycle: clear all valid bits of the set and reset its round-robin pointer to 0. After the last set (16 cycles at default) the FSM SHALL go to READY.
REQ-021 In INIT, rd_req_i and upd_valid_i SHALL be ignored and alloc_valid_o SHALL be 0.
REQ-022 A flush_i pulse in READY SHALL enter INIT with the counter at 0. A flush_i pulse in INIT SHALL restart the sweep at 0.
REQ-023 If flush_i and upd_valid_i are asserted in the same READY cycle, flush SHALL win and the update SHALL be dropped.
REQ-024 Lookup: rd_req_i in READY SHALL register the set contents, so rdata_*_o is valid on the next cycle (1-cycle latency).
REQ-025 rdata_*_o SHALL hold its last value when rd_req_i is 0.
REQ-026 Hit update (upd_valid_i=1, upd_hit_i=1): no entry change and no pointer change.
REQ-027 Miss update (upd_valid_i=1, upd_hit_i=0): victim = lowest-numbered invalid way of the set. If all ways are valid, victim = pointer[set], and the pointer then increments modulo N_WAY.
REQ-028 On a miss update, the victim SHALL be written {valid=1, upd_tag_i}.
REQ-029 Each miss update SHALL produce exactly one alloc_valid_o pulse on the next cycle, with alloc_way_o = victim.
REQ-030 alloc_evict_o SHALL be 1 if the victim was valid. evict_tag_o SHALL be the victim's old tag when evicting, else 0.
REQ-031 Write-first: if a lookup and a miss update target the same set in the same cycle, the lookup SHALL return the post-update contents.
REQ-032 Back-to-back updates to the same set SHALL each see the result of the previous update (no lost allocation).

Reset
REQ-033 Asserting rst_n=0 SHALL asynchronously force: state=INIT, sweep counter=0, rdata_valid_o all 0, rdata_tag_o all 0, ready_o=0, alloc_valid_o=0, alloc_way_o=0, alloc_evict_o=0, evict_tag_o=0.
REQ-034 Array contents are don't-care at reset and SHALL be cleared only by the INIT sweep.
REQ-035 A reset during the sweep or during traffic SHALL abandon the operation and restart INIT from set 0.

Verification
REQ-036 Release reset, hold no inputs -> ready_o=0 for exactly 16 cycles, then 1; a lookup of set 5 returns all valid=0.
REQ-037 Four misses to set 3 with tags 0x11, 0x22, 0x33, 0x44 -> alloc_way_o=0,1,2,3 with alloc_evict_o=0; a fifth miss with tag 0x55 -> way 0, alloc_evict_o=1, evict_tag_o=0x11; a sixth miss -> way 1.
REQ-038 Hit update on set 3, way 2 -> no alloc_valid_o pulse; the next miss still selects the way given by the unchanged pointer.
REQ-039 Same-cycle lookup and miss to set 7 with tag 0xABCDE -> the next-cycle rdata shows that way valid=1 with tag 0x0ABCDE.
REQ-040 flush_i together with upd_valid_i in READY -> no alloc pulse, ready_o=0 for 16 cycles, and all sets read invalid afterwards.
REQ-041 Assert rst_n=0 during INIT at counter=9 -> outputs go to reset values immediately, and the sweep restarts from 0 after rst_n rises.
